// File: rtl/noise_sched.sv
// noise_sched: round-robin scheduler sharing one 8-bit signed noise source
// between N_REQ requesters. One requester is served at a time for a burst of
// req_len valid samples; samples are forwarded with one cycle of latency.
//
// Handshake: a requester raises req[i] with req_len[i] stable and keeps req[i]
// high until it sees burst_done[i]. gnt[i] marks the requester being served.
// Each sample for it is qualified by samp_valid[i]. Dropping req[i] while
// streaming aborts the burst without a burst_done pulse. The source is
// qualified by noise_in_valid only; noise_en is a request to the source, not a
// qualifier, so a trailing sample after noise_en falls is ignored.
module noise_sched #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  output logic [N_REQ-1:0]       gnt,
  output logic                   noise_en,
  input  logic signed [7:0]      noise_in,
  input  logic                   noise_in_valid,
  output logic signed [7:0]      samp_out,
  output logic [N_REQ-1:0]       samp_valid,
  output logic [N_REQ-1:0]       burst_done,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] sel;
  logic             found;
  logic [LEN_W-1:0] sel_len;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             owner_req;

  // Index base+off taken modulo N_REQ (off is always below N_REQ).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Circular search from rr_ptr; scanning from the far end lets the nearest
  // requester win.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(rr_ptr, k)]) begin
        found = 1'b1;
        sel   = wrap_idx(rr_ptr, k);
      end
    end
    sel_len = req_len[int'(sel)*LEN_W +: LEN_W];
  end

  // The served requester is still asking while its req bit overlaps gnt.
  assign owner_req = |(req & gnt);
  assign state_dbg = state;

  // Scheduler FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      gnt        <= '0;
      noise_en   <= 1'b0;
      samp_out   <= '0;
      samp_valid <= '0;
      burst_done <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          samp_valid <= '0;
          burst_done <= '0;
          if (found) begin
            gnt      <= ONE << sel;
            len_q    <= sel_len;
            cnt      <= '0;
            rr_ptr   <= wrap_idx(sel, 1);
            noise_en <= (sel_len != '0);
            busy     <= 1'b1;
            state    <= STREAM;
          end
        end
        STREAM: begin
          samp_valid <= '0;
          burst_done <= '0;
          if (len_q == '0) begin
            // Zero-length burst completes without touching the source.
            burst_done <= gnt;
            gnt        <= '0;
            noise_en   <= 1'b0;
            state      <= DRAIN;
          end else if (!owner_req) begin
            gnt      <= '0;
            noise_en <= 1'b0;
            state    <= DRAIN;
          end else if (noise_in_valid) begin
            samp_out   <= noise_in;
            samp_valid <= gnt;
            cnt        <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) begin
              burst_done <= gnt;
              gnt        <= '0;
              noise_en   <= 1'b0;
              state      <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // A trailing source sample lands here and is dropped.
          samp_valid <= '0;
          burst_done <= '0;
          gnt        <= '0;
          noise_en   <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          gnt      <= '0;
          noise_en <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noise_sched.sv
// Bench for noise_sched: directed scenarios plus randomized bursts, checked
// against a transaction-level model (round-robin pick, sample queue).
module tb_noise_sched;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        req;
  logic [63:0]       req_len;
  logic [3:0]        gnt;
  logic              noise_en;
  logic signed [7:0] noise_in;
  logic              noise_in_valid;
  logic signed [7:0] samp_out;
  logic [3:0]        samp_valid;
  logic [3:0]        burst_done;
  logic              busy;
  logic [1:0]        state_dbg;

  int         n_vec = 0;
  int         n_err = 0;
  int         model_ptr = 0;
  logic [7:0] exp_q[$];

  noise_sched #(.N_REQ(4), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .gnt(gnt),
    .noise_en(noise_en), .noise_in(noise_in), .noise_in_valid(noise_in_valid),
    .samp_out(samp_out), .samp_valid(samp_valid), .burst_done(burst_done),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks / model helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int l);
    req_len[i*16 +: 16] = 16'(l);
  endtask

  task automatic drive_noise(input logic v);
    noise_in_valid = v;
    noise_in       = 8'($urandom_range(0, 255));
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] r;
    r = 4'b0;
    r[i] = 1'b1;
    return r;
  endfunction

  // First requester at or after ptr in circular order.
  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; noise_in_valid = 1'b0; noise_in = 8'sd0;
    for (int i = 0; i < 4; i++) set_len(i, 3);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      n_vec++; if (noise_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_en_busy: got en=%b busy=%b want 0 0", noise_en, busy); end
      n_vec++; if (samp_valid !== 4'b0 || burst_done !== 4'b0 || samp_out !== 8'sd0) begin n_err++; $display("FAIL reset_samp: got sv=%b bd=%b so=%h want 0", samp_valid, burst_done, samp_out); end
    end
    rst = 1'b0;
    tick();
    n_vec++; if (gnt !== 4'b0001 || noise_en !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL reset_first_grant: got gnt=%b en=%b busy=%b want 0001 1 1", gnt, noise_en, busy); end
    model_ptr = 1;
    req = 4'b0;
    tick();
    n_vec++; if (gnt !== 4'b0 || burst_done !== 4'b0 || noise_en !== 1'b0) begin n_err++; $display("FAIL reset_cleanup_abort: got gnt=%b bd=%b en=%b want 0 0 0", gnt, burst_done, noise_en); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_cleanup_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_single_burst();
    int sel;
    logic [7:0] exp_s;
    sel = rr_pick(4'b0100, model_ptr);
    model_ptr = (sel + 1) % 4;
    req = 4'b0100; set_len(2, 5); drive_noise(1'b1);
    tick();
    n_vec++; if (gnt !== oh(sel) || noise_en !== 1'b1 || busy !== 1'b1 || samp_valid !== 4'b0) begin n_err++; $display("FAIL single_grant: got gnt=%b en=%b busy=%b sv=%b want %b 1 1 0000", gnt, noise_en, busy, samp_valid, oh(sel)); end
    for (int k = 1; k <= 5; k++) begin
      drive_noise(1'b1); exp_q.push_back(noise_in);
      tick();
      exp_s = exp_q.pop_front();
      n_vec++; if (samp_valid !== oh(sel) || samp_out !== exp_s) begin n_err++; $display("FAIL single_sample%0d: got sv=%b so=%h want %b %h", k, samp_valid, samp_out, oh(sel), exp_s); end
      n_vec++; if (burst_done !== ((k == 5) ? oh(sel) : 4'b0) || noise_en !== (k < 5)) begin n_err++; $display("FAIL single_done%0d: got bd=%b en=%b want %b %b", k, burst_done, noise_en, (k == 5) ? oh(sel) : 4'b0, k < 5); end
      if (k == 5) req = 4'b0;
    end
    drive_noise(1'b1);
    tick();
    n_vec++; if (samp_valid !== 4'b0 || gnt !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_after: got sv=%b gnt=%b busy=%b want 0 0 0", samp_valid, gnt, busy); end
    noise_in_valid = 1'b0;
  endtask

  task automatic test_gapped();
    int sel, got;
    int pat[6];
    logic [7:0] exp_s;
    pat = '{1, 0, 1, 1, 0, 1};
    sel = rr_pick(4'b1000, model_ptr);
    model_ptr = (sel + 1) % 4;
    req = 4'b1000; set_len(3, 4); noise_in_valid = 1'b0;
    tick();
    n_vec++; if (gnt !== oh(sel)) begin n_err++; $display("FAIL gapped_grant: got %b want %b", gnt, oh(sel)); end
    got = 0;
    for (int p = 0; p < 6; p++) begin
      drive_noise(pat[p] != 0);
      if (pat[p] != 0) exp_q.push_back(noise_in);
      tick();
      if (pat[p] != 0) begin
        got++;
        exp_s = exp_q.pop_front();
        n_vec++; if (samp_valid !== oh(sel) || samp_out !== exp_s) begin n_err++; $display("FAIL gapped_sample%0d: got sv=%b so=%h want %b %h", p, samp_valid, samp_out, oh(sel), exp_s); end
      end else begin
        n_vec++; if (samp_valid !== 4'b0) begin n_err++; $display("FAIL gapped_idle%0d: got sv=%b want 0000", p, samp_valid); end
      end
      n_vec++; if (burst_done !== ((pat[p] != 0 && got == 4) ? oh(sel) : 4'b0)) begin n_err++; $display("FAIL gapped_done%0d: got %b", p, burst_done); end
    end
    req = 4'b0; noise_in_valid = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0 || gnt !== 4'b0) begin n_err++; $display("FAIL gapped_after: got busy=%b gnt=%b want 0 0000", busy, gnt); end
  endtask

  task automatic test_round_robin();
    int sel;
    logic [7:0] exp_s;
    req = 4'b1011;
    for (int i = 0; i < 4; i++) set_len(i, 2);
    for (int b = 0; b < 4; b++) begin
      sel = rr_pick(req, model_ptr);
      model_ptr = (sel + 1) % 4;
      noise_in_valid = 1'b0;
      tick();
      n_vec++; if (gnt !== oh(sel)) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", b, gnt, oh(sel)); end
      for (int k = 1; k <= 2; k++) begin
        drive_noise(1'b1); exp_q.push_back(noise_in);
        tick();
        exp_s = exp_q.pop_front();
        n_vec++; if (samp_valid !== oh(sel) || samp_out !== exp_s || burst_done !== ((k == 2) ? oh(sel) : 4'b0)) begin n_err++; $display("FAIL rr_sample%0d_%0d: got sv=%b so=%h bd=%b want %b %h", b, k, samp_valid, samp_out, burst_done, oh(sel), exp_s); end
      end
      n_vec++; if (gnt !== 4'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rr_drain%0d: got gnt=%b busy=%b want 0000 1", b, gnt, busy); end
      if (b == 3) req = 4'b0;
      noise_in_valid = 1'b0;
      tick();
      n_vec++; if (gnt !== 4'b0 || busy !== 1'b0 || burst_done !== 4'b0) begin n_err++; $display("FAIL rr_idle%0d: got gnt=%b busy=%b bd=%b want 0 0 0", b, gnt, busy, burst_done); end
    end
  endtask

  task automatic test_zero_len();
    int sel;
    sel = rr_pick(4'b0010, model_ptr);
    model_ptr = (sel + 1) % 4;
    req = 4'b0010; set_len(1, 0); drive_noise(1'b1);
    tick();
    n_vec++; if (gnt !== oh(sel) || noise_en !== 1'b0 || burst_done !== 4'b0) begin n_err++; $display("FAIL zero_grant: got gnt=%b en=%b bd=%b want %b 0 0", gnt, noise_en, burst_done, oh(sel)); end
    drive_noise(1'b1);
    tick();
    n_vec++; if (burst_done !== oh(sel) || noise_en !== 1'b0 || samp_valid !== 4'b0 || gnt !== 4'b0) begin n_err++; $display("FAIL zero_done: got bd=%b en=%b sv=%b gnt=%b want %b 0 0 0", burst_done, noise_en, samp_valid, gnt, oh(sel)); end
    req = 4'b0;
    tick();
    n_vec++; if (busy !== 1'b0 || noise_en !== 1'b0 || samp_valid !== 4'b0) begin n_err++; $display("FAIL zero_idle: got busy=%b en=%b sv=%b want 0 0 0", busy, noise_en, samp_valid); end
    noise_in_valid = 1'b0;
  endtask

  task automatic test_abort();
    int sel;
    logic [7:0] exp_s;
    sel = rr_pick(4'b0001, model_ptr);
    model_ptr = (sel + 1) % 4;
    req = 4'b0001; set_len(0, 8); noise_in_valid = 1'b0;
    tick();
    n_vec++; if (gnt !== oh(sel)) begin n_err++; $display("FAIL abort_grant: got %b want %b", gnt, oh(sel)); end
    for (int k = 0; k < 2; k++) begin
      drive_noise(1'b1); exp_q.push_back(noise_in);
      tick();
      exp_s = exp_q.pop_front();
      n_vec++; if (samp_valid !== oh(sel) || samp_out !== exp_s) begin n_err++; $display("FAIL abort_sample%0d: got sv=%b so=%h want %b %h", k, samp_valid, samp_out, oh(sel), exp_s); end
    end
    req = 4'b0; noise_in_valid = 1'b0;
    tick();
    n_vec++; if (gnt !== 4'b0 || noise_en !== 1'b0 || burst_done !== 4'b0 || samp_valid !== 4'b0) begin n_err++; $display("FAIL abort_drain: got gnt=%b en=%b bd=%b sv=%b want 0", gnt, noise_en, burst_done, samp_valid); end
    drive_noise(1'b1);
    tick();
    n_vec++; if (samp_valid !== 4'b0 || burst_done !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_trailing: got sv=%b bd=%b busy=%b want 0 0 0", samp_valid, burst_done, busy); end
    noise_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    int sel;
    sel = rr_pick(4'b0100, model_ptr);
    req = 4'b0100; set_len(2, 10); noise_in_valid = 1'b0;
    tick();
    n_vec++; if (gnt !== oh(sel)) begin n_err++; $display("FAIL rstmid_grant: got %b want %b", gnt, oh(sel)); end
    for (int k = 0; k < 3; k++) begin
      drive_noise(1'b1);
      tick();
    end
    rst = 1'b1;
    tick();
    n_vec++; if (gnt !== 4'b0 || noise_en !== 1'b0 || busy !== 1'b0 || samp_valid !== 4'b0 || burst_done !== 4'b0 || samp_out !== 8'sd0) begin n_err++; $display("FAIL rstmid_outputs: got gnt=%b en=%b busy=%b sv=%b bd=%b so=%h want all 0", gnt, noise_en, busy, samp_valid, burst_done, samp_out); end
    rst = 1'b0; req = 4'b0; noise_in_valid = 1'b0;
    model_ptr = 0;
    tick();
    n_vec++; if (busy !== 1'b0 || gnt !== 4'b0) begin n_err++; $display("FAIL rstmid_idle: got busy=%b gnt=%b want 0 0000", busy, gnt); end
  endtask

  task automatic test_random();
    logic [3:0] mask;
    int lens[4];
    int sel, len, got, abort_n, guard;
    logic v;
    logic [7:0] exp_s;
    for (int it = 0; it < 40; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        lens[i] = $urandom_range(0, 6);
        set_len(i, lens[i]);
      end
      req = mask; noise_in_valid = 1'b0;
      sel = rr_pick(mask, model_ptr);
      len = lens[sel];
      model_ptr = (sel + 1) % 4;
      abort_n = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
      tick();
      n_vec++; if (gnt !== oh(sel) || noise_en !== (len != 0) || busy !== 1'b1) begin n_err++; $display("FAIL rand%0d_grant: got gnt=%b en=%b busy=%b want %b %b 1", it, gnt, noise_en, busy, oh(sel), len != 0); end
      if (len == 0) begin
        tick();
        n_vec++; if (burst_done !== oh(sel) || noise_en !== 1'b0 || gnt !== 4'b0 || samp_valid !== 4'b0) begin n_err++; $display("FAIL rand%0d_zero: got bd=%b en=%b gnt=%b sv=%b want %b 0 0 0", it, burst_done, noise_en, gnt, samp_valid, oh(sel)); end
      end else begin
        got = 0; guard = 0;
        while (got < len && got != abort_n && guard < 100) begin
          v = ($urandom_range(0, 3) != 0);
          drive_noise(v);
          if (v) exp_q.push_back(noise_in);
          tick();
          guard++;
          if (v) begin
            got++;
            exp_s = exp_q.pop_front();
            n_vec++; if (samp_valid !== oh(sel) || samp_out !== exp_s) begin n_err++; $display("FAIL rand%0d_sample%0d: got sv=%b so=%h want %b %h", it, got, samp_valid, samp_out, oh(sel), exp_s); end
          end else begin
            n_vec++; if (samp_valid !== 4'b0) begin n_err++; $display("FAIL rand%0d_gap: got sv=%b want 0000", it, samp_valid); end
          end
          n_vec++; if (burst_done !== ((got == len) ? oh(sel) : 4'b0) || noise_en !== (got < len) || gnt !== ((got < len) ? oh(sel) : 4'b0)) begin n_err++; $display("FAIL rand%0d_ctrl%0d: got bd=%b en=%b gnt=%b", it, got, burst_done, noise_en, gnt); end
        end
        if (guard >= 100) begin n_vec++; n_err++; $display("FAIL rand%0d_budget: got %0d of %0d samples", it, got, len); end
        if (got == abort_n) begin
          req = 4'b0; noise_in_valid = 1'b0;
          tick();
          n_vec++; if (gnt !== 4'b0 || noise_en !== 1'b0 || burst_done !== 4'b0 || samp_valid !== 4'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rand%0d_abort: got gnt=%b en=%b bd=%b sv=%b busy=%b", it, gnt, noise_en, burst_done, samp_valid, busy); end
        end
      end
      req = 4'b0;
      drive_noise(1'($urandom_range(0, 1)));
      tick();
      n_vec++; if (samp_valid !== 4'b0 || gnt !== 4'b0 || busy !== 1'b0 || burst_done !== 4'b0) begin n_err++; $display("FAIL rand%0d_drain: got sv=%b gnt=%b busy=%b bd=%b want 0", it, samp_valid, gnt, busy, burst_done); end
      noise_in_valid = 1'b0;
      exp_q.delete();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; req = 4'b0; req_len = '0; noise_in = 8'sd0; noise_in_valid = 1'b0;
    test_reset();
    test_single_burst();
    test_gapped();
    test_round_robin();
    test_zero_len();
    test_abort();
    test_reset_mid_stream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noise_sched.md
Name: noise_sched

Overview:
- Round-robin scheduler that shares one discrete noise source (8-bit signed samples with a valid strobe) between N_REQ requesters.
- Each requester asks for a burst of noise samples of a given length.
- The block grants one requester at a time, drives the source enable, counts valid samples, and routes each sample to the granted requester.
- Sits between the noise source and the per-channel Rx noise-injection paths of the SERDES simulation.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LEN_W, 16, width of each burst-length field.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request; held high until that requester's burst_done.
- req_len  in  N_REQ*LEN_W  packed burst lengths, requester i at bits [i*LEN_W +: LEN_W]; sampled at grant.
- gnt  out  N_REQ  one-hot grant, or all zero.
- noise_en  out  1  enable to the noise source.
- noise_in  in  8  signed sample from the source.
- noise_in_valid  in  1  source sample valid.
- samp_out  out  8  signed sample forwarded to the granted requester.
- samp_valid  out  N_REQ  one-hot valid qualifying samp_out.
- burst_done  out  N_REQ  one-cycle pulse to the requester whose burst ended.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at posedge), values on the next cycle: state=IDLE, gnt=0, noise_en=0, samp_out=0, samp_valid=0, burst_done=0, busy=0, rr_ptr=0, cnt=0. Reset mid-burst aborts immediately with no burst_done.
- State IDLE:
  - If any req is high, choose the first requester at or after rr_ptr, in circular order.
  - Latch len=req_len[sel] and set cnt=0.
  - Set gnt[sel]=1 and rr_ptr=(sel+1) mod N_REQ.
  - If len==0: pulse burst_done[sel] next cycle, go to DRAIN, never assert noise_en.
  - Otherwise: go to STREAM with noise_en=1.
  - If no req is high, stay in IDLE.
- State STREAM:
  - noise_en=1 and gnt held.
  - On each noise_in_valid: samp_out<=noise_in, samp_valid[sel]<=1 (1-cycle latency), cnt++.
  - Cycles with noise_in_valid=0 are not counted, and samp_valid=0.
  - When a valid sample arrives with cnt==len-1: forward it, pulse burst_done[sel] in the same cycle as its samp_valid, set noise_en<=0, go to DRAIN.
  - If req[sel] drops while in STREAM: abort, noise_en<=0, no burst_done, go to DRAIN.
- State DRAIN:
  - Exactly one cycle; gnt=0, noise_en=0.
  - Any noise_in_valid here (the source's registered trailing sample) is discarded, and samp_valid stays 0.
  - Then go to IDLE.
- Simultaneous requests are resolved strictly by rr_ptr.
- A requester raising req while another is being served waits; there is no preemption.
- Burst length range is 1..2^LEN_W-1 samples; cnt is LEN_W bits and never wraps.
- busy=1 in STREAM and DRAIN.
- Minimum turnaround from one grant to the next is len valid cycles + 2.
- samp_valid and gnt are never multi-hot.

Test Plan:
- Reset: hold rst 3 cycles with req=4'b1111 -> gnt=0, noise_en=0, busy=0 throughout; first grant goes to gnt=4'b0001 on the cycle after rst falls.
- Single burst: req[2]=1, len=5, noise_in_valid always 1 -> gnt=4'b0100, exactly 5 samp_valid[2] pulses whose samp_out equals noise_in delayed 1 cycle; burst_done[2] coincides with the 5th; noise_en low for the next cycle.
- Gapped source: len=4, noise_in_valid pattern 1,0,1,1,0,1 -> 4 forwarded samples; done on the 6th source cycle; invalid cycles produce no samp_valid.
- Round-robin: req=4'b1011 held, each len=2 -> grant order 0,1,3,0; each done is followed by exactly one DRAIN cycle.
- Zero length: req[1]=1, len=0 -> noise_en never asserted; burst_done[1] pulses one cycle after grant; back to IDLE within 3 cycles.
- Abort and discard: req[0] drops after 2 of 8 samples -> no burst_done; the trailing noise_in_valid in DRAIN is not forwarded. Separately, rst mid-STREAM -> all outputs 0 next cycle.
